// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared constants and controller state type for UART RX |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int FRAME_BITS = 10;
  // One full frame plus one bit of slack before a silent receiver is declared stuck.
  localparam int WDOG_TICKS = (FRAME_BITS + 1) * OVERSAMPLE;

  typedef enum logic [1:0] {
    CTRL_RESET   = 2'd0,
    CTRL_RUN     = 2'd1,
    CTRL_RECOVER = 2'd2
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// +------------------------------------------------------------------+
// | uart_byte_fifo : synchronous FIFO with extra-MSB full/empty logic  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module uart_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (c_AW + 1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (c_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// +------------------------------------------------------------------+
// | uart_rx_ctrl : baud gen, reset sequencing, watchdog and RX FIFO    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_byte_i,
  input  logic                          rx_byte_valid_i,
  input  logic                          rx_baud_rst_i,
  output logic                          rx_rst_n_o,
  output logic                          baud_tick_o,
  output logic [7:0]                    m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  input  logic                          clr_i
);

  localparam int c_DIV_W  = $clog2(CLK_DIV);
  localparam int c_RST_W  = $clog2(RST_CYCLES + 1);
  localparam int c_WDOG_W = $clog2(WDOG_TICKS + 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_TICKS - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic [c_RST_W-1:0]  r_rst_cnt;
  logic [c_RST_W-1:0]  w_rst_cnt_nxt;
  logic                r_rx_rst_n;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_baud_tick;
  logic [c_WDOG_W-1:0] r_wdog_cnt;
  logic                r_overrun;
  logic                r_frame_err;

  logic w_wdog_hit;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_overrun_set;

  // The tick about to be counted is the one that completes the watchdog window.
  assign w_wdog_hit = (r_state == CTRL_RUN) && !rx_baud_rst_i && !rx_byte_valid_i &&
                      r_baud_tick && (r_wdog_cnt == c_WDOG_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    case (r_state)
      CTRL_RESET, CTRL_RECOVER: begin
        if (r_rst_cnt == c_RST_LAST) begin
          w_state_nxt   = CTRL_RUN;
          w_rst_cnt_nxt = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + c_RST_W'(1);
        end
      end
      CTRL_RUN: begin
        if (w_wdog_hit) begin
          w_state_nxt   = CTRL_RECOVER;
          w_rst_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = CTRL_RESET;
        w_rst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CTRL_RESET;
      r_rst_cnt  <= '0;
      r_rx_rst_n <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_rx_rst_n <= (w_state_nxt == CTRL_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rx_baud_rst_i || !r_rx_rst_n) begin
      r_div_cnt   <= '0;
      r_baud_tick <= 1'b0;
    end else if (r_div_cnt == c_DIV_LAST) begin
      r_div_cnt   <= '0;
      r_baud_tick <= 1'b1;
    end else begin
      r_div_cnt   <= r_div_cnt + c_DIV_W'(1);
      r_baud_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rx_baud_rst_i || rx_byte_valid_i || w_wdog_hit || (r_state != CTRL_RUN)) begin
      r_wdog_cnt <= '0;
    end else if (r_baud_tick) begin
      r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
    end
  end

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_pop         = !w_empty && m_ready_i;
  assign w_push_req    = rx_byte_valid_i && (r_state == CTRL_RUN);
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_overrun_set = w_push_req && w_full && !w_pop;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (rx_byte_i),
    .o_data  (m_data_o),
    .o_level (fifo_level_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set) r_overrun <= 1'b1;
      else if (clr_i)    r_overrun <= 1'b0;
      if (w_wdog_hit)    r_frame_err <= 1'b1;
      else if (clr_i)    r_frame_err <= 1'b0;
    end
  end

  assign rx_rst_n_o  = r_rx_rst_n;
  assign baud_tick_o = r_baud_tick;
  assign m_valid_o   = !w_empty;
  assign overrun_o   = r_overrun;
  assign frame_err_o = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// +------------------------------------------------------------------+
// | tb_uart_rx_ctrl : uart_rx_ctrl bench with emulated receiver + model |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_ctrl;

  localparam int DEPTH       = 8;
  localparam int FRAME_TICKS = 10 * 16;
  localparam int WDOG_TICKS  = 11 * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte_i = 8'h00;
  logic       rx_byte_valid_i = 1'b0;
  logic       rx_baud_rst_i = 1'b1;
  logic       m_ready_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       rx_rst_n_o;
  logic       baud_tick_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic [3:0] fifo_level_o;
  logic       overrun_o;
  logic       frame_err_o;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];
  bit         ovr_m = 1'b0;
  int         ready_mode = 0;

  uart_rx_ctrl #(.CLK_DIV(4), .FIFO_DEPTH(DEPTH), .RST_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_byte_i       (rx_byte_i),
    .rx_byte_valid_i (rx_byte_valid_i),
    .rx_baud_rst_i   (rx_baud_rst_i),
    .rx_rst_n_o      (rx_rst_n_o),
    .baud_tick_o     (baud_tick_o),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .fifo_level_o    (fifo_level_o),
    .overrun_o       (overrun_o),
    .frame_err_o     (frame_err_o),
    .clr_i           (clr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one clock: update the reference queue from this cycle's inputs, then check occupancy.
  task automatic cycle();
    bit do_pop;
    bit was_full;
    if (ready_mode == 1) m_ready_i = ($urandom_range(0, 599) == 0);
    if (ready_mode == 2) m_ready_i = ($urandom_range(0, 7) == 0);
    do_pop   = m_ready_i && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (do_pop) begin
      tests++;
      if (m_data_o !== q[0]) begin
        fails++;
        $display("FAIL pop_data: got %02h expected %02h", m_data_o, q[0]);
      end
    end
    if (rst) begin
      q.delete();
      ovr_m = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (rx_byte_valid_i) begin
        if (!was_full || do_pop) q.push_back(rx_byte_i);
        else ovr_m = 1'b1;
      end
      if (clr_i && !(rx_byte_valid_i && was_full && !do_pop)) ovr_m = 1'b0;
    end
    @(posedge clk);
    #1;
    tests++;
    if (fifo_level_o !== q.size() || m_valid_o !== (q.size() != 0) || overrun_o !== ovr_m) begin
      fails++;
      $display("FAIL occupancy: level=%0d valid=%b ovr=%b expected level=%0d valid=%b ovr=%b",
               fifo_level_o, m_valid_o, overrun_o, q.size(), (q.size() != 0), ovr_m);
    end
  endtask

  // Emulated receiver: idle one cycle, consume one frame of ticks, then emit the byte.
  task automatic rx_frame(input logic [7:0] b, input bit pop_with, input bit clr_with);
    int ticks;
    int budget;
    ticks  = 0;
    budget = 0;
    rx_baud_rst_i = 1'b1;
    cycle();
    rx_baud_rst_i = 1'b0;
    while (ticks < FRAME_TICKS && budget < 4000) begin
      cycle();
      budget++;
      if (baud_tick_o === 1'b1) ticks++;
    end
    tests++;
    if (ticks != FRAME_TICKS) begin
      fails++;
      $display("FAIL frame_ticks: got %0d ticks required %0d", ticks, FRAME_TICKS);
    end
    rx_byte_i       = b;
    rx_byte_valid_i = 1'b1;
    if (pop_with) m_ready_i = 1'b1;
    if (clr_with) clr_i = 1'b1;
    cycle();
    rx_byte_valid_i = 1'b0;
    rx_baud_rst_i   = 1'b1;
    clr_i           = 1'b0;
    if (pop_with) m_ready_i = 1'b0;
  endtask

  task automatic drain();
    m_ready_i = 1'b1;
    repeat (DEPTH + 1) cycle();
    m_ready_i = 1'b0;
    tests++;
    if (fifo_level_o !== 4'd0) begin
      fails++;
      $display("FAIL drain_level: got %0d required 0", fifo_level_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    tests++;
    if (rx_rst_n_o !== 1'b0 || baud_tick_o !== 1'b0 || m_valid_o !== 1'b0 ||
        fifo_level_o !== 4'd0 || overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rst_n=%b tick=%b valid=%b level=%0d ovr=%b ferr=%b required all 0",
               rx_rst_n_o, baud_tick_o, m_valid_o, fifo_level_o, overrun_o, frame_err_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (rx_rst_n_o !== (i >= 1)) begin
        fails++;
        $display("FAIL reset_pulse: cycle %0d rst_n=%b required %b", i, rx_rst_n_o, (i >= 1));
      end
    end
  endtask

  task automatic test_baud_tick();
    int seen;
    seen = 0;
    rx_baud_rst_i = 1'b1;
    repeat (20) begin
      cycle();
      if (baud_tick_o !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL tick_held: got %0d ticks required 0", seen);
    end
    rx_baud_rst_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      tests++;
      if (baud_tick_o !== ((i % 4) == 0)) begin
        fails++;
        $display("FAIL tick_period: cycle %0d tick=%b required %b", i, baud_tick_o, ((i % 4) == 0));
      end
    end
    rx_baud_rst_i = 1'b1;
    cycle();
  endtask

  task automatic test_single_byte();
    m_ready_i = 1'b1;
    rx_frame(8'hA5, 1'b0, 1'b0);
    tests++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'hA5) begin
      fails++;
      $display("FAIL single_byte: valid=%b data=%02h required 1 a5", m_valid_o, m_data_o);
    end
    cycle();
    m_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b0, 1'b0);
    tests++;
    if (fifo_level_o !== 4'd8 || overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun: level=%0d ovr=%b required 8 1", fifo_level_o, overrun_o);
    end
    drain();
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    tests++;
    if (overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: ovr=%b required 0", overrun_o);
    end
  endtask

  task automatic test_full_with_pop();
    for (int i = 0; i < DEPTH; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    rx_frame(8'hC7, 1'b1, 1'b0);
    tests++;
    if (fifo_level_o !== 4'd8 || overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL full_pop: level=%0d ovr=%b required 8 0", fifo_level_o, overrun_o);
    end
    drain();
  endtask

  task automatic test_bad_stop();
    int ticks;
    int budget;
    ticks  = 0;
    budget = 0;
    rx_baud_rst_i = 1'b1;
    cycle();
    rx_baud_rst_i = 1'b0;
    while (ticks < WDOG_TICKS && budget < 6000) begin
      cycle();
      budget++;
      if (baud_tick_o === 1'b1) ticks++;
    end
    tests++;
    if (ticks != WDOG_TICKS || frame_err_o !== 1'b0 || rx_rst_n_o !== 1'b1) begin
      fails++;
      $display("FAIL wdog_pre: ticks=%0d ferr=%b rst_n=%b required %0d 0 1",
               ticks, frame_err_o, rx_rst_n_o, WDOG_TICKS);
    end
    cycle();
    tests++;
    if (frame_err_o !== 1'b1 || rx_rst_n_o !== 1'b0) begin
      fails++;
      $display("FAIL wdog_hit: ferr=%b rst_n=%b required 1 0", frame_err_o, rx_rst_n_o);
    end
    rx_baud_rst_i = 1'b1;
    cycle();
    tests++;
    if (rx_rst_n_o !== 1'b0) begin
      fails++;
      $display("FAIL recover_len: rst_n=%b required 0", rx_rst_n_o);
    end
    cycle();
    tests++;
    if (rx_rst_n_o !== 1'b1) begin
      fails++;
      $display("FAIL recover_end: rst_n=%b required 1", rx_rst_n_o);
    end
    m_ready_i = 1'b1;
    rx_frame(8'h3C, 1'b0, 1'b0);
    tests++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h3C || frame_err_o !== 1'b1) begin
      fails++;
      $display("FAIL after_recover: valid=%b data=%02h ferr=%b required 1 3c 1",
               m_valid_o, m_data_o, frame_err_o);
    end
    cycle();
    m_ready_i = 1'b0;
  endtask

  task automatic test_flags();
    for (int i = 0; i < DEPTH; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    rx_frame(8'h99, 1'b0, 1'b1);
    tests++;
    if (overrun_o !== 1'b1 || frame_err_o !== 1'b0) begin
      fails++;
      $display("FAIL set_over_clr: ovr=%b ferr=%b required 1 0", overrun_o, frame_err_o);
    end
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    tests++;
    if (overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL clr_alone: ovr=%b required 0", overrun_o);
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 2; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    rx_baud_rst_i = 1'b0;
    repeat (37) cycle();
    rst = 1'b1;
    cycle();
    rx_baud_rst_i = 1'b1;
    tests++;
    if (rx_rst_n_o !== 1'b0 || baud_tick_o !== 1'b0 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL midframe_rst: rst_n=%b tick=%b ferr=%b ovr=%b required all 0",
               rx_rst_n_o, baud_tick_o, frame_err_o, overrun_o);
    end
    rst = 1'b0;
    cycle();
    cycle();
    tests++;
    if (rx_rst_n_o !== 1'b1) begin
      fails++;
      $display("FAIL midframe_rearm: rst_n=%b required 1", rx_rst_n_o);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      ready_mode = $urandom_range(0, 2);
      if (ready_mode == 0) m_ready_i = 1'b0;
      rx_frame(8'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
      end
    end
    ready_mode = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_baud_tick();
    test_single_byte();
    test_overrun();
    test_full_with_pop();
    test_bad_stop();
    test_flags();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
